// File: rtl/deconv1_module.sv
// deconv1_module: 1-D transposed convolution over a small block of frames.
// A start request captures the input frames. One input frame is then
// scattered per cycle into per-channel accumulators. A final cycle rounds,
// sums across input channels, adds the bias and saturates into the
// registered result.
module deconv1_module #(
  parameter int DATA_WIDTH       = 16,
  parameter int FRACTIONAL_BITS  = 8,
  parameter int NUM_IN_CHANNELS  = 1,
  parameter int NUM_OUT_CHANNELS = 2,
  parameter int KERNEL_SIZE      = 3,
  parameter int STRIDE           = 2,
  parameter int PADDING          = 1,
  parameter int OUTPUT_PADDING   = 1,
  parameter int NUM_IN_FRAMES    = 4,
  localparam int NUM_OUT_FRAMES  = (NUM_IN_FRAMES - 1) * STRIDE - 2 * PADDING
                                   + KERNEL_SIZE + OUTPUT_PADDING,
  parameter logic signed [DATA_WIDTH-1:0] WEIGHTS [NUM_IN_CHANNELS][NUM_OUT_CHANNELS][KERNEL_SIZE] =
    '{'{'{16'sd64, 16'sd128, 16'sd64}, '{16'sd256, 16'sd0, -16'sd128}}},
  parameter logic signed [DATA_WIDTH-1:0] BIASES [NUM_OUT_CHANNELS] = '{16'sd0, 16'sd16}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic signed [DATA_WIDTH-1:0] i_data [NUM_IN_CHANNELS][NUM_IN_FRAMES],
  output logic                         o_busy,
  output logic                         o_done_tick,
  output logic signed [DATA_WIDTH-1:0] o_result [NUM_OUT_CHANNELS][NUM_OUT_FRAMES]
);

  // Accumulators are wide enough that a full scatter can never wrap.
  localparam int ACC_W   = 2 * DATA_WIDTH + 8;
  // The cross-channel sum needs headroom for every input channel plus the bias.
  localparam int SUM_W   = ACC_W + $clog2(NUM_IN_CHANNELS + 1) + 1;
  localparam int FRAME_W = (NUM_IN_FRAMES > 1) ? $clog2(NUM_IN_FRAMES) : 1;

  localparam logic signed [ACC_W-1:0] ROUND_CONST = ACC_W'(longint'(1) << (FRACTIONAL_BITS - 1));
  localparam longint SAT_MAX = (longint'(1) << (DATA_WIDTH - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) << (DATA_WIDTH - 1));

  typedef enum logic [1:0] {
    IDLE,
    SCATTER,
    FINALIZE
  } state_t;

  state_t state_reg, state_next;
  logic   start_accept;

  logic [FRAME_W-1:0]          frame_reg;
  logic                        done_reg;
  logic signed [DATA_WIDTH-1:0] data_reg   [NUM_IN_CHANNELS][NUM_IN_FRAMES];
  logic signed [ACC_W-1:0]      acc_reg    [NUM_IN_CHANNELS][NUM_OUT_CHANNELS][NUM_OUT_FRAMES];
  logic signed [ACC_W-1:0]      acc_next   [NUM_IN_CHANNELS][NUM_OUT_CHANNELS][NUM_OUT_FRAMES];
  logic signed [DATA_WIDTH-1:0] result_reg [NUM_OUT_CHANNELS][NUM_OUT_FRAMES];
  logic signed [DATA_WIDTH-1:0] result_next[NUM_OUT_CHANNELS][NUM_OUT_FRAMES];

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Starts are only honoured from IDLE, so a request made
  // during the done cycle launches the next block immediately.
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          start_accept = 1'b1;
          state_next   = SCATTER;
        end
      end
      SCATTER: begin
        if (frame_reg == FRAME_W'(NUM_IN_FRAMES - 1)) begin
          state_next = FINALIZE;
        end
      end
      FINALIZE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scatter the current frame. Each output position gathers the kernel taps
  // that land on it this cycle. Taps that fall outside the output window
  // never match any position, so they are dropped.
  always_comb begin
    acc_next = acc_reg;
    for (int ic = 0; ic < NUM_IN_CHANNELS; ic++) begin
      for (int oc = 0; oc < NUM_OUT_CHANNELS; oc++) begin
        for (int o = 0; o < NUM_OUT_FRAMES; o++) begin
          for (int k = 0; k < KERNEL_SIZE; k++) begin
            if (int'(frame_reg) * STRIDE + k - PADDING == o) begin
              acc_next[ic][oc][o] = acc_next[ic][oc][o]
                                  + ACC_W'(data_reg[ic][frame_reg]) * ACC_W'(WEIGHTS[ic][oc][k]);
            end
          end
        end
      end
    end
  end

  // Finalize: round each channel's accumulator, sum the channels, add the
  // bias and clamp to the sample range.
  for (genvar gi = 0; gi < NUM_OUT_CHANNELS; gi++) begin : g_oc
    for (genvar go = 0; go < NUM_OUT_FRAMES; go++) begin : g_of
      logic signed [SUM_W-1:0]      sum;
      logic signed [ACC_W-1:0]      rounded;
      logic signed [DATA_WIDTH-1:0] sat;

      // Round-half-up followed by an arithmetic (flooring) shift, then clamp.
      always_comb begin
        sum     = SUM_W'(BIASES[gi]);
        rounded = '0;
        for (int ic = 0; ic < NUM_IN_CHANNELS; ic++) begin
          rounded = (acc_reg[ic][gi][go] + ROUND_CONST) >>> FRACTIONAL_BITS;
          sum     = sum + SUM_W'(rounded);
        end
        if (sum > SUM_W'(SAT_MAX)) begin
          sat = DATA_WIDTH'(SAT_MAX);
        end else if (sum < SUM_W'(SAT_MIN)) begin
          sat = DATA_WIDTH'(SAT_MIN);
        end else begin
          sat = sum[DATA_WIDTH-1:0];
        end
      end

      assign result_next[gi][go] = sat;
    end
  end

  // Datapath registers. The input is captured on the start edge so later
  // input changes are ignored. The result is only written when leaving
  // FINALIZE, so it updates in a single edge and is never partially written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg <= '0;
      done_reg  <= 1'b0;
      for (int ic = 0; ic < NUM_IN_CHANNELS; ic++) begin
        for (int i = 0; i < NUM_IN_FRAMES; i++) begin
          data_reg[ic][i] <= '0;
        end
        for (int oc = 0; oc < NUM_OUT_CHANNELS; oc++) begin
          for (int o = 0; o < NUM_OUT_FRAMES; o++) begin
            acc_reg[ic][oc][o] <= '0;
          end
        end
      end
      for (int oc = 0; oc < NUM_OUT_CHANNELS; oc++) begin
        for (int o = 0; o < NUM_OUT_FRAMES; o++) begin
          result_reg[oc][o] <= '0;
        end
      end
    end else begin
      done_reg <= 1'b0;
      if (start_accept) begin
        data_reg  <= i_data;
        frame_reg <= '0;
        for (int ic = 0; ic < NUM_IN_CHANNELS; ic++) begin
          for (int oc = 0; oc < NUM_OUT_CHANNELS; oc++) begin
            for (int o = 0; o < NUM_OUT_FRAMES; o++) begin
              acc_reg[ic][oc][o] <= '0;
            end
          end
        end
      end else if (state_reg == SCATTER) begin
        acc_reg   <= acc_next;
        frame_reg <= frame_reg + FRAME_W'(1);
      end else if (state_reg == FINALIZE) begin
        result_reg <= result_next;
        done_reg   <= 1'b1;
      end
    end
  end

  assign o_busy      = (state_reg != IDLE);
  assign o_done_tick = done_reg;
  assign o_result    = result_reg;

endmodule

// File: tb/tb_deconv1_module.sv
// Testbench for deconv1_module. The expected results come from a gather-form
// reference model: each output position collects every tap that lands on it.
// The bench covers directed cases, randomized frame blocks, held start,
// and reset in mid-computation.
module tb_deconv1_module;
  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int NIC = 1;
  localparam int NOC = 2;
  localparam int K   = 3;
  localparam int S   = 2;
  localparam int P   = 1;
  localparam int NIF = 4;
  localparam int NOF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic signed [DW-1:0] i_data [NIC][NIF];
  logic o_busy;
  logic o_done_tick;
  logic signed [DW-1:0] o_result [NOC][NOF];

  longint w_tab [NIC][NOC][K] = '{'{'{64, 128, 64}, '{256, 0, -128}}};
  longint b_tab [NOC] = '{0, 16};
  longint stim    [NIC][NIF];
  longint exp_res [NOC][NOF];

  int checks = 0;
  int errors = 0;
  int txn = 0;

  deconv1_module dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_data     (i_data),
    .o_busy     (o_busy),
    .o_done_tick(o_done_tick),
    .o_result   (o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Gather-form model: each output position collects every tap that lands on
  // it, with plain integer arithmetic and floor division.
  task automatic compute_expected();
    longint acc, total;
    for (int oc = 0; oc < NOC; oc++) begin
      for (int o = 0; o < NOF; o++) begin
        total = b_tab[oc];
        for (int ic = 0; ic < NIC; ic++) begin
          acc = 0;
          for (int i = 0; i < NIF; i++)
            for (int k = 0; k < K; k++)
              if (i * S + k - P == o) acc += stim[ic][i] * w_tab[ic][oc][k];
          total += (acc + (longint'(1) << (FB - 1))) >>> FB;
        end
        if (total > 32767) total = 32767;
        if (total < -32768) total = -32768;
        exp_res[oc][o] = total;
      end
    end
  endtask

  task automatic load_inputs();
    for (int ic = 0; ic < NIC; ic++)
      for (int i = 0; i < NIF; i++)
        i_data[ic][i] = DW'(stim[ic][i]);
  endtask

  task automatic check_results(input string tag);
    for (int oc = 0; oc < NOC; oc++)
      for (int o = 0; o < NOF; o++)
        check($sformatf("%s_r%0d_%0d", tag, oc, o), o_result[oc][o], exp_res[oc][o]);
  endtask

  task automatic set_req27();
    stim[0][0] = 256; stim[0][1] = 512; stim[0][2] = 256; stim[0][3] = 0;
  endtask

  // One full transaction. If scramble is set, the input is overwritten just
  // after the start edge; the result must still reflect the captured frames.
  task automatic run_case(input string tag, input bit scramble, input bit use_1000);
    int lat;
    compute_expected();
    @(negedge clk);
    load_inputs();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    if (scramble) begin
      for (int ic = 0; ic < NIC; ic++)
        for (int i = 0; i < NIF; i++)
          i_data[ic][i] = use_1000 ? DW'(1000) : DW'($urandom);
    end
    check({tag, "_busy_start"}, o_busy, 1);
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk);
      #1;
      if (o_done_tick) begin
        lat = t;
        break;
      end
      check({tag, "_busy_mid"}, o_busy, 1);
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_busy_done"}, o_busy, 0);
    check_results(tag);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, o_done_tick, 0);
    txn++;
    $display("txn %0d %s latency %0d r0_0 %0d r1_1 %0d", txn, tag, lat, o_result[0][0], o_result[1][1]);
  endtask

  initial begin
    logic signed [DW-1:0] v;
    int mode;

    for (int ic = 0; ic < NIC; ic++)
      for (int i = 0; i < NIF; i++)
        i_data[ic][i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done_tick, 0);
    for (int oc = 0; oc < NOC; oc++)
      for (int o = 0; o < NOF; o++)
        check("rst_result", o_result[oc][o], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed reference case, with the input changed to 1000 after start
    set_req27();
    run_case("req27", 1'b1, 1'b1);
    check("req27_r0_2", o_result[0][2], 256);
    check("req27_r1_1", o_result[1][1], 400);
    check("req27_r1_5", o_result[1][5], -112);

    // Saturation and negative rounding
    stim[0][0] = -32768; stim[0][1] = 32767; stim[0][2] = 0; stim[0][3] = 0;
    run_case("sat", 1'b0, 1'b0);
    check("sat_r1_1", o_result[1][1], 32767);
    check("sat_r0_0", o_result[0][0], -16384);
    check("sat_r0_1", o_result[0][1], 0);

    // Randomized blocks
    for (int n = 0; n < 12; n++) begin
      for (int ic = 0; ic < NIC; ic++) begin
        for (int i = 0; i < NIF; i++) begin
          mode = int'($urandom_range(0, 2));
          if (mode == 0) v = DW'($urandom);
          else if (mode == 1) v = DW'(int'($urandom_range(0, 2000)) - 1000);
          else v = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
          stim[ic][i] = v;
        end
      end
      run_case($sformatf("rand%0d", n), 1'b1, 1'b0);
    end

    // Start held high for 8 edges: two back-to-back blocks
    set_req27();
    compute_expected();
    @(negedge clk);
    load_inputs();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    check("hold_busy_t0", o_busy, 1);
    for (int t = 1; t <= 16; t++) begin
      @(posedge clk);
      #1;
      if (t == 7) i_start = 1'b0;
      check($sformatf("hold_done_t%0d", t), o_done_tick, (t == 5 || t == 11) ? 1 : 0);
      check($sformatf("hold_busy_t%0d", t), o_busy, (t <= 10 && t != 5) ? 1 : 0);
    end
    check_results("hold");
    txn++;
    $display("txn %0d hold two computations", txn);

    // Reset in mid-scatter
    set_req27();
    @(negedge clk);
    stim[0][1] = 100;
    load_inputs();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done_tick, 0);
    for (int oc = 0; oc < NOC; oc++)
      for (int o = 0; o < NOF; o++)
        check("abort_result", o_result[oc][o], 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", o_done_tick, 0);
      check("abort_idle", o_busy, 0);
    end
    txn++;
    $display("txn %0d reset abort", txn);
    set_req27();
    run_case("restart", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
